// File: rtl/ccff_pkg.sv
// ccff_pkg: shared types and helpers for the ccff chain loader.
//   state_t     - loader FSM states (2-bit encoding)
//   CRC16_POLY  - CRC-16-CCITT polynomial
//   CRC16_INIT  - CRC-16-CCITT initial value
//   crc16_step  - one MSB-first serial CRC step
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16: 1-bit serial CRC-16-CCITT register.
//   i_clk      in   clock
//   i_rst      in   asynchronous active-high reset (loads CRC16_INIT)
//   i_init     in   re-initialise to CRC16_INIT (priority over i_en)
//   i_en       in   advance the CRC by i_bit
//   i_bit      in   serial data bit
//   o_crc      out  current CRC value
//   o_crc_next out  value the CRC takes after absorbing i_bit
module ccff_crc16
    import ccff_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc,
    output logic [15:0] o_crc_next
);

    logic [15:0] r_crc;
    logic [15:0] w_step;

    assign w_step = crc16_step(r_crc, i_bit);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_init) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= w_step;
        end
    end

    assign o_crc      = r_crc;
    assign o_crc_next = w_step;

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words onto a tile's ccff chain.
// Optional feature macro: CCFF_CRC_EN (CRC-16 over shifted bits + error flag).
//   prog_clk       in   programming clock, rising edge
//   pReset         in   asynchronous active-high reset
//   start_i        in   begin a load (IDLE/DONE only)
//   abort_i        in   synchronous abort to IDLE (wins over everything)
//   word_i         in   configuration word, MSB shifted first
//   word_valid_i   in   word_i valid
//   word_ready_o   out  high in FETCH; word taken on valid & ready
//   ccff_head_o    out  registered serial data to ccff_head
//   ccff_clk_en_o  out  registered chain shift enable (high in SHIFT only)
//   busy_o         out  high in FETCH/SHIFT
//   done_o         out  high in DONE
//   crc_ref_i      in   expected CRC of the shifted stream
//   crc_o          out  running CRC of shifted bits (0 without CCFF_CRC_EN)
//   error_o        out  CRC mismatch, valid while done_o (0 without CCFF_CRC_EN)
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 28,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              ccff_head_o,
    output logic              ccff_clk_en_o,
    output logic              busy_o,
    output logic              done_o,
    input  logic [15:0]       crc_ref_i,
    output logic [15:0]       crc_o,
    output logic              error_o
);

    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int SCW = $clog2(WORD_W + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BCW-1:0]    r_bit_cnt;
    logic [SCW-1:0]    r_sh_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_head;
    logic              r_clk_en;
    logic [BCW-1:0]    w_bit_inc;
    logic [SCW-1:0]    w_sh_inc;
    logic              w_start;
    logic              w_accept;
    logic              w_shifting;
    logic              w_head_nxt;

    assign w_bit_inc  = r_bit_cnt + BCW'(1);
    assign w_sh_inc   = r_sh_cnt + SCW'(1);
    assign w_shifting = (r_state == SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        if (abort_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_state_nxt = FETCH;
                        w_start     = 1'b1;
                    end
                end
                FETCH: begin
                    if (word_valid_i) begin
                        w_state_nxt = SHIFT;
                        w_accept    = 1'b1;
                    end
                end
                SHIFT: begin
                    // Chain length wins when it coincides with a word boundary.
                    if (w_bit_inc == BCW'(CHAIN_LEN)) begin
                        w_state_nxt = DONE;
                    end else if (w_sh_inc == SCW'(WORD_W)) begin
                        w_state_nxt = FETCH;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        w_state_nxt = FETCH;
                        w_start     = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // The word is held pre-shifted so the head register is loaded one cycle
    // ahead; head and enable are then aligned with the SHIFT state itself.
    always_comb begin
        w_head_nxt = 1'b0;
        if (w_accept) begin
            w_head_nxt = word_i[WORD_W-1];
        end else if (w_shifting && (w_state_nxt == SHIFT)) begin
            w_head_nxt = r_word[WORD_W-1];
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_sh_cnt  <= '0;
            r_word    <= '0;
            r_head    <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_head   <= w_head_nxt;
            r_clk_en <= (w_state_nxt == SHIFT);
            if (w_start) begin
                r_bit_cnt <= '0;
            end
            if (w_accept) begin
                r_word   <= word_i << 1;
                r_sh_cnt <= '0;
            end else if (w_shifting) begin
                r_word    <= r_word << 1;
                r_sh_cnt  <= w_sh_inc;
                r_bit_cnt <= w_bit_inc;
            end
        end
    end

    assign word_ready_o  = (r_state == FETCH);
    assign busy_o        = (r_state == FETCH) || (r_state == SHIFT);
    assign done_o        = (r_state == DONE);
    assign ccff_head_o   = r_head;
    assign ccff_clk_en_o = r_clk_en;

`ifdef CCFF_CRC_EN
    logic [15:0] w_crc;
    logic [15:0] w_crc_next;
    logic        r_error;

    ccff_crc16 u_crc (
        .i_clk      (prog_clk),
        .i_rst      (pReset),
        .i_init     (w_start),
        .i_en       (w_shifting),
        .i_bit      (r_head),
        .o_crc      (w_crc),
        .o_crc_next (w_crc_next)
    );

    // Compare against the post-last-bit CRC so the flag is valid on DONE entry.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_error <= 1'b0;
        end else if (w_shifting && (w_state_nxt == DONE)) begin
            r_error <= (w_crc_next != crc_ref_i);
        end else if (w_state_nxt != DONE) begin
            r_error <= 1'b0;
        end
    end

    assign crc_o   = w_crc;
    assign error_o = r_error;
`else
    logic w_unused_crc_ref;
    assign w_unused_crc_ref = ^crc_ref_i;
    assign crc_o   = '0;
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed self-checking bench for ccff_chain_loader
// (CHAIN_LEN=28, WORD_W=8), with a 28-DFF chain model on the gated clock.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 28;
    localparam int WORD_W    = 8;
    localparam logic [27:0] EXP_BITS = 28'hA53CFF9;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start_i;
    logic        abort_i;
    logic [7:0]  word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        ccff_head_o;
    logic        ccff_clk_en_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] crc_ref_i;
    logic [15:0] crc_o;
    logic        error_o;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    logic [27:0] chain;
    int cyc;
    int viol;
    int base;
    logic [15:0] golden;
    logic [15:0] crc_rst;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .word_i        (word_i),
        .word_valid_i  (word_valid_i),
        .word_ready_o  (word_ready_o),
        .ccff_head_o   (ccff_head_o),
        .ccff_clk_en_o (ccff_clk_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .crc_ref_i     (crc_ref_i),
        .crc_o         (crc_o),
        .error_o       (error_o)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: first shifted bit ends up in chain[27].
    always @(posedge prog_clk) begin
        if (ccff_clk_en_o) begin
            en_cnt <= en_cnt + 1;
            chain  <= {chain[26:0], ccff_head_o};
        end
    end

    function automatic logic [7:0] stream_word(input int idx);
        case (idx)
            0:       return 8'hA5;
            1:       return 8'h3C;
            2:       return 8'hFF;
            default: return 8'h9E;
        endcase
    endfunction

    function automatic logic [15:0] golden_crc(input logic [27:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 27; i >= 0; i--) begin
            if (c[15] ^ bits[i]) c = (c << 1) ^ 16'h1021;
            else                 c = c << 1;
        end
        return c;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start, feeds the 4-word stream (gap idle FETCH cycles before each
    // word), optionally pulses start again at cycle poke, stops at done_o or
    // after stop_bits enables. cycles counts negedges after the start pulse.
    task automatic run_load(input int gap, input int stop_bits, input int poke,
                            output int cycles, output int v);
        int   idx;
        int   g;
        int   b0;
        logic acc;
        idx = 0; g = gap; v = 0; cycles = 0; acc = 1'b0; b0 = en_cnt;
        @(negedge prog_clk);
        start_i      = 1'b1;
        word_valid_i = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge prog_clk);
            start_i = (c == poke);
            cycles  = c;
            if (acc) begin
                idx++;
                g = gap;
            end
            if (word_ready_o && ccff_clk_en_o) v++;
            if (done_o) break;
            if (stop_bits > 0 && (en_cnt - b0) >= stop_bits) break;
            if (g > 0) begin
                word_valid_i = 1'b0;
                if (word_ready_o) g--;
            end else if (idx < 4) begin
                word_valid_i = 1'b1;
                word_i       = stream_word(idx);
            end else begin
                word_valid_i = 1'b0;
            end
            acc = word_valid_i && word_ready_o;
        end
        start_i      = 1'b0;
        word_valid_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"}, word_ready_o, 0);
        check_val({tag, "_head"},  ccff_head_o, 0);
        check_val({tag, "_clken"}, ccff_clk_en_o, 0);
        check_val({tag, "_busy"},  busy_o, 0);
        check_val({tag, "_done"},  done_o, 0);
        check_val({tag, "_crc"},   crc_o, crc_rst);
        check_val({tag, "_err"},   error_o, 0);
    endtask

    initial begin
`ifdef CCFF_CRC_EN
        crc_rst = 16'hFFFF;
`else
        crc_rst = 16'h0000;
`endif
        golden       = golden_crc(EXP_BITS);
        pReset       = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        word_valid_i = 1'b0;
        word_i       = 8'h00;
        crc_ref_i    = golden;
        repeat (2) @(negedge prog_clk);
        check_idle_outputs("reset");
        pReset = 1'b0;
        @(negedge prog_clk);
        check_val("idle_busy", busy_o, 0);

        // 1: back-to-back stream
        base = en_cnt;
        run_load(0, 0, 0, cyc, viol);
        check_val("t1_cycles", cyc, 33);
        check_val("t1_enables", en_cnt - base, 28);
        check_val("t1_chain", chain, EXP_BITS);
        check_val("t1_first_bit_last_dff", chain[27], 1);
        check_val("t1_done", done_o, 1);
        check_val("t1_busy", busy_o, 0);
        check_val("t1_ready", word_ready_o, 0);
        check_val("t1_fetch_en", viol, 0);
`ifdef CCFF_CRC_EN
        check_val("t1_crc", crc_o, golden);
`else
        check_val("t1_crc", crc_o, 0);
`endif
        check_val("t1_err", error_o, 0);
        repeat (4) @(negedge prog_clk);
        check_val("t1_hold_done", done_o, 1);
        check_val("t1_hold_enables", en_cnt - base, 28);
        check_val("t1_hold_clken", ccff_clk_en_o, 0);

        // 2: reload from DONE with 5-cycle under-runs, wrong CRC reference
        crc_ref_i = golden ^ 16'h0001;
        base = en_cnt;
        run_load(5, 0, 0, cyc, viol);
        check_val("t2_cycles", cyc, 53);
        check_val("t2_enables", en_cnt - base, 28);
        check_val("t2_chain", chain, EXP_BITS);
        check_val("t2_gap_en", viol, 0);
        check_val("t2_done", done_o, 1);
`ifdef CCFF_CRC_EN
        check_val("t2_crc", crc_o, golden);
        check_val("t2_err", error_o, 1);
        @(negedge prog_clk);
        check_val("t2_err_hold", error_o, 1);
`else
        check_val("t2_err", error_o, 0);
`endif
        crc_ref_i = golden;

        // 3: reset after 13 shifted bits, then a clean load
        base = en_cnt;
        run_load(0, 13, 0, cyc, viol);
        check_val("t3_partial_enables", en_cnt - base, 13);
        check_val("t3_partial_busy", busy_o, 1);
        pReset = 1'b1;
        #1;
        check_idle_outputs("t3_rst");
        @(negedge prog_clk);
        pReset = 1'b0;
        base = en_cnt;
        run_load(0, 0, 0, cyc, viol);
        check_val("t3_cycles", cyc, 33);
        check_val("t3_enables", en_cnt - base, 28);
        check_val("t3_chain", chain, EXP_BITS);
        check_val("t3_err", error_o, 0);

        // 4: start during SHIFT ignored; abort+start in DONE -> IDLE
        base = en_cnt;
        run_load(0, 0, 5, cyc, viol);
        check_val("t4_cycles", cyc, 33);
        check_val("t4_enables", en_cnt - base, 28);
        check_val("t4_chain", chain, EXP_BITS);
        @(negedge prog_clk);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge prog_clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check_val("t4_abort_done", done_o, 0);
        check_val("t4_abort_busy", busy_o, 0);
        check_val("t4_abort_err", error_o, 0);
        @(negedge prog_clk);
        check_val("t4_abort_stays_idle", busy_o, 0);
        check_val("t4_abort_ready", word_ready_o, 0);

        // abort mid-SHIFT: the in-flight enabled cycle completes, then stops
        base = en_cnt;
        run_load(0, 18, 0, cyc, viol);
        check_val("ab_clken_before", ccff_clk_en_o, 1);
        abort_i = 1'b1;
        @(negedge prog_clk);
        abort_i = 1'b0;
        check_val("ab_clken", ccff_clk_en_o, 0);
        check_val("ab_busy", busy_o, 0);
        repeat (3) @(negedge prog_clk);
        check_val("ab_enables", en_cnt - base, 19);
        base = en_cnt;
        run_load(0, 0, 0, cyc, viol);
        check_val("ab_reload_cycles", cyc, 33);
        check_val("ab_reload_chain", chain, EXP_BITS);
        check_val("ab_reload_enables", en_cnt - base, 28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
